// File: rtl/ser_10b_tx_if.sv
// ser_10b_tx_if: code-group handshake between the 8b/10b encoder and ser_10b_tx.
//   word_in    : 10-bit code group (encoder -> tx)
//   word_valid : word_in is valid      (encoder -> tx)
//   word_ready : tx takes word_in on this edge if word_valid (tx -> encoder)
interface ser_10b_tx_if;
  logic [9:0] word_in;
  logic       word_valid;
  logic       word_ready;

  modport master (output word_in, output word_valid, input  word_ready);
  modport slave  (input  word_in, input  word_valid, output word_ready);
endinterface

// File: rtl/ser_10b_tx.sv
// ser_10b_tx: parallel-to-serial transmit stage behind the 8b/10b encoder.
// Takes 10-bit code groups over a valid/ready handshake, shifts them out one
// bit per clk, and uses a one-word holding register so consecutive groups
// stream with no gap. Counts underruns (stream gaps after a word started).
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   bus (slave)   : word_in / word_valid / word_ready handshake
//   ser_out       : serial data bit
//   ser_valid     : ser_out carries a data-word bit
//   word_start    : first bit of a data word is on ser_out
//   underrun_cnt  : saturating underrun count
// Parameter LSB_FIRST: 1 = word_in[0] sent first, 0 = word_in[9] first.
// Build option SER_IDLE_COMMA_EN: when defined, idle time is filled with
// K28.5 RD- comma groups and data starts only on a 10-bit boundary.
module ser_10b_tx #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  ser_10b_tx_if.slave       bus,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_start,
  output logic [7:0]        underrun_cnt
);

  localparam int unsigned W_WORD = 10;
  localparam int unsigned W_BIT  = 4;
  localparam int unsigned W_CNT  = 8;
`ifdef SER_IDLE_COMMA_EN
  // Bit i of this constant is the i-th comma bit on the line.
  localparam logic [W_WORD-1:0] COMMA_SEQ = 10'h17C;
`endif

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             r_state, w_state_nxt;
  logic [W_BIT-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [W_WORD-1:0]  r_shift, w_shift_nxt;
  logic [W_WORD-1:0]  r_hold, w_hold_nxt;
  logic               r_hold_full, w_hold_full_nxt;
  logic [W_CNT-1:0]   r_urun, w_urun_nxt;
  logic               w_last_bit;
  logic               w_load_edge;
  logic               w_accept;
  logic [W_WORD-1:0]  w_shift_adv;

  assign w_last_bit = (r_bit_cnt == W_BIT'(9));

  // Load edge: end of a 10-bit slot (data or comma), or any idle edge without commas.
`ifdef SER_IDLE_COMMA_EN
  assign w_load_edge = w_last_bit;
`else
  assign w_load_edge = (r_state == S_IDLE) || w_last_bit;
`endif

  // Ready depends on registered state only; held low during reset.
  assign bus.word_ready = rst_n && (!r_hold_full || w_load_edge);
  assign w_accept       = bus.word_valid && bus.word_ready;

  assign w_shift_adv = LSB_FIRST ? {1'b0, r_shift[W_WORD-1:1]}
                                 : {r_shift[W_WORD-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_urun      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_urun      <= w_urun_nxt;
    end
  end

  // Next-state: reload from hold or bypass at load edges, otherwise shift.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_urun_nxt      = r_urun;
    if (w_load_edge) begin
      w_bit_cnt_nxt = '0;
      if (r_hold_full) begin
        w_shift_nxt = r_hold;
        w_state_nxt = S_SHIFT;
        if (w_accept) begin
          w_hold_nxt = bus.word_in;
        end else begin
          w_hold_full_nxt = 1'b0;
        end
      end else if (w_accept) begin
        w_shift_nxt = bus.word_in;
        w_state_nxt = S_SHIFT;
      end else begin
        w_state_nxt = S_IDLE;
        if ((r_state == S_SHIFT) && (r_urun != {W_CNT{1'b1}})) begin
          w_urun_nxt = r_urun + W_CNT'(1);
        end
      end
    end else begin
      w_bit_cnt_nxt = r_bit_cnt + W_BIT'(1);
      w_shift_nxt   = w_shift_adv;
      if (w_accept) begin
        w_hold_nxt      = bus.word_in;
        w_hold_full_nxt = 1'b1;
      end
    end
  end

  // Line outputs decoded from registered state only.
  always_comb begin
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    word_start = 1'b0;
    if (r_state == S_SHIFT) begin
      ser_valid  = 1'b1;
      word_start = (r_bit_cnt == '0);
      ser_out    = LSB_FIRST ? r_shift[0] : r_shift[W_WORD-1];
    end else begin
`ifdef SER_IDLE_COMMA_EN
      ser_out = COMMA_SEQ[r_bit_cnt];
`endif
    end
  end

  assign underrun_cnt = r_urun;

endmodule

// File: tb/tb_ser_10b_tx.sv
// tb_ser_10b_tx: self-checking bench for ser_10b_tx. Two instances run in
// lock-step on identical stimulus, one LSB-first and one MSB-first. Accepted
// words push their expected line sequence (bit i = i-th bit sent) into a
// per-instance queue; a negedge monitor reassembles words from ser_out and
// pops/compares them.
module tb_ser_10b_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ser_10b_tx_if ifl ();
  ser_10b_tx_if ifm ();

  logic [1:0] so, sv, ws;
  logic [7:0] uc0, uc1;

  ser_10b_tx #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(ifl),
    .ser_out(so[0]), .ser_valid(sv[0]), .word_start(ws[0]), .underrun_cnt(uc0)
  );
  ser_10b_tx #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(ifm),
    .ser_out(so[1]), .ser_valid(sv[1]), .word_start(ws[1]), .underrun_cnt(uc1)
  );

  typedef struct {
    logic [9:0] w;
    logic [9:0] el;   // expected line order, LSB-first instance
    logic [9:0] em;   // expected line order, MSB-first instance
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] sb0[$];
  logic [9:0] sb1[$];
  logic [9:0] acc[2];
  logic [3:0] nb[2];
  int         cyc = 0;
  int         last_start = 0;
  bit         have_start = 1'b0;
  bit         b2b_chk = 1'b0;
  logic [9:0] comma_seq = 10'h17C;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] w);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[9-i];
    return r;
  endfunction

  // Reassemble one instance's line output into words and score them.
  task automatic mon(input int k);
    logic [9:0] e;
    bit         have;
    if (sv[k]) begin
      chk("word_start_pos", int'(ws[k]), int'(nb[k] == 4'd0));
      if (ws[k]) begin
`ifdef SER_IDLE_COMMA_EN
        chk("start_on_boundary", cyc % 10, 0);
`endif
        if (k == 0) begin
          if (b2b_chk && have_start) chk("start_spacing", cyc - last_start, 10);
          last_start = cyc;
          have_start = 1'b1;
        end
      end
      acc[k][nb[k]] = so[k];
      nb[k] = nb[k] + 4'd1;
      if (nb[k] == 4'd10) begin
        e = '0;
        if (k == 0) begin
          have = (sb0.size() > 0);
          if (have) e = sb0.pop_front();
        end else begin
          have = (sb1.size() > 0);
          if (have) e = sb1.pop_front();
        end
        chk("word_expected", int'(have), 1);
        if (have) chk("word_bits", int'(acc[k]), int'(e));
        nb[k] = 4'd0;
      end
    end else begin
      chk("gap_inside_word", int'(nb[k]), 0);
      nb[k] = 4'd0;
      chk("idle_word_start", int'(ws[k]), 0);
`ifdef SER_IDLE_COMMA_EN
      chk("comma_bit", int'(so[k]), int'(comma_seq[cyc % 10]));
`else
      chk("idle_ser_out", int'(so[k]), 0);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      nb[0] = 4'd0;
      nb[1] = 4'd0;
      have_start = 1'b0;
      sb0.delete();
      sb1.delete();
    end else begin
      mon(0);
      mon(1);
      cyc++;
    end
  end

  task automatic idle();
    ifl.word_valid = 1'b0;
    ifm.word_valid = 1'b0;
  endtask

  // Present a word and hold it until accepted; leaves word_valid high.
  task automatic send(input logic [9:0] w, input logic [9:0] el, input logic [9:0] em);
    bit ok;
    ifl.word_in = w;    ifm.word_in = w;
    ifl.word_valid = 1'b1; ifm.word_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = ifl.word_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", int'(ok), 1);
    if (ok) begin
      sb0.push_back(el);
      sb1.push_back(em);
    end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("ready_in_reset", int'(ifl.word_ready), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!sv[0] && t < 40) begin @(negedge clk); t++; end
    while (sv[0] && t < 40) begin @(negedge clk); t++; end
    chk("word_done_in_time", int'(t < 40), 1);
  endtask

  vec_t tbl[6];

  initial begin
    int cnt;
    int t;
    logic [9:0] w;

    tbl[0] = '{10'h3FF, 10'h3FF, 10'h3FF};
    tbl[1] = '{10'h000, 10'h000, 10'h000};
    tbl[2] = '{10'h2AA, 10'h2AA, 10'h155};
    tbl[3] = '{10'h001, 10'h001, 10'h200};
    tbl[4] = '{10'h0F0, 10'h0F0, 10'h03C};
    tbl[5] = '{10'h17C, 10'h17C, 10'h0FA};

    ifl.word_in = '0; ifm.word_in = '0;
    idle();

    // Reset values.
    do_reset();
    @(negedge clk);
    chk("rst_ser_out",    int'(so[0]), 0);
    chk("rst_ser_valid",  int'(sv[0]), 0);
    chk("rst_word_start", int'(ws[0]), 0);
    chk("rst_underrun",   int'(uc0), 0);
    chk("rst_ready",      int'(ifl.word_ready), 1);
    @(posedge clk); #1;

    // Single word 0x2AA from idle.
    send(10'h2AA, 10'h2AA, 10'h155);
    idle();
    @(negedge clk);
`ifndef SER_IDLE_COMMA_EN
    chk("latency_valid", int'(sv[0]), 1);
    chk("latency_start", int'(ws[0]), 1);
`endif
    chk("single_urun_before", int'(uc0), 0);
    cnt = int'(sv[0]);
    repeat (24) begin @(negedge clk); cnt += int'(sv[0]); end
    chk("single_valid_cycles", cnt, 10);
    chk("single_underrun", int'(uc0), 1);
    @(posedge clk); #1;

    // Back-to-back table stream with word_valid held high.
    do_reset();
    b2b_chk = 1'b1;
    for (int i = 0; i < 6; i++) send(tbl[i].w, tbl[i].el, tbl[i].em);
    idle();
    @(negedge clk);
    chk("b2b_streaming", int'(sv[0]), 1);
    chk("b2b_no_underrun", int'(uc0), 0);
    repeat (30) @(negedge clk);
    b2b_chk = 1'b0;
    chk("b2b_end_underrun", int'(uc0), 1);
    chk("b2b_sb_l_empty", sb0.size(), 0);
    chk("b2b_sb_m_empty", sb1.size(), 0);
    @(posedge clk); #1;

    // 300 isolated words: underrun count saturates at 255.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      w = 10'($urandom_range(0, 1023));
      send(w, w, rev10(w));
      idle();
      wait_done();
      if (i == 9) chk("urun_after_10", int'(uc0), 10);
      repeat (3) @(posedge clk);
      #1;
    end
    chk("urun_sat_l", int'(uc0), 255);
    chk("urun_sat_m", int'(uc1), 255);
    chk("urun_sb_empty", sb0.size(), 0);

    // Reset during bit 4 of 0x155 with 0x0F0 held.
    do_reset();
    send(10'h155, 10'h155, 10'h2AA);
    idle();
    t = 0;
    while (!ws[0] && t < 30) begin @(posedge clk); #1; t++; end
    chk("mid_start_seen", int'(ws[0]), 1);
    send(10'h0F0, 10'h0F0, 10'h03C);
    idle();
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("mid_bit4_l", int'(so[0]), 1);
    chk("mid_bit4_m", int'(so[1]), 0);
    chk("mid_hold_full_ready", int'(ifl.word_ready), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_ser_out",    int'(so[0]), 0);
    chk("mid_rst_ser_valid",  int'(sv[0]), 0);
    chk("mid_rst_word_start", int'(ws[0]), 0);
    chk("mid_rst_ready",      int'(ifl.word_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready_after", int'(ifl.word_ready), 1);
    cnt = int'(sv[0]) + int'(sv[1]);
    repeat (30) begin @(negedge clk); cnt += int'(sv[0]) + int'(sv[1]); end
    chk("mid_nothing_sent", cnt, 0);
    @(posedge clk); #1;

    // Idle for 25 cycles after reset, then one word (0x001 exercises bit order).
    do_reset();
    repeat (25) @(posedge clk);
    #1;
    send(10'h001, 10'h001, 10'h200);
    idle();
    wait_done();
    repeat (3) @(negedge clk);
    chk("final_sb_l_empty", sb0.size(), 0);
    chk("final_sb_m_empty", sb1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_err=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
